// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file writeback path.
//   XLEN       : register data width
//   AW         : register address width (32 architectural registers)
//   NUM_WB_SRC : number of writeback sources (ALU = 0, LSU = 1)
//   wb_req_t   : one writeback request {addr, data}
//   rr_pick    : 2-way round-robin grant selection
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int XLEN       = 32;
  localparam int AW         = 5;
  localparam int NUM_WB_SRC = 2;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // last_src is the index of the source that won the previous transfer.
  // Under contention the other source wins, so reset value 1 lets source 0
  // win the first contention.
  function automatic logic [NUM_WB_SRC-1:0] rr_pick(
    input logic [NUM_WB_SRC-1:0] req,
    input logic                  last_src
  );
    logic [NUM_WB_SRC-1:0] gnt;
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_src ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a last-grant flop.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   req_i    : request vector, bit n = source n valid
//   hold_i   : suppresses all grants
//   grant_o  : one-hot (or zero) grant, combinational from req_i/hold_i/state
// A grant is only ever raised for a requesting source, so any nonzero grant
// is a completed transfer and advances the round-robin pointer.
// ---------------------------------------------------------------------------
module rr_arb2
  import rf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_WB_SRC-1:0] req_i,
  input  logic                  hold_i,
  output logic [NUM_WB_SRC-1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_o = '0;
    if (!hold_i) begin
      grant_o = rr_pick(req_i, last_grant_q);
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (|grant_o) begin
      last_grant_d = grant_o[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Merges the ALU and LSU writeback streams onto the register file's single
// write port through a one-entry stage, and exposes the staged entry for
// read-port bypass.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   wb0_valid/ready/addr/data        : ALU writeback (source 0)
//   wb1_valid/ready/addr/data        : LSU writeback (source 1)
//   rf_hold                          : freezes register-file writes
//   wr_en/wr_addr/wr_data            : register-file write port
//   fwd_addr1/fwd_addr2              : read addresses presented to the RF
//   fwd_hit1/fwd_hit2/fwd_data       : bypass of the staged write
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int XLEN = rf_pkg::XLEN,
  parameter int AW   = rf_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb0_valid,
  output logic            wb0_ready,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_valid,
  output logic            wb1_ready,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  input  logic            rf_hold,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   fwd_addr1,
  input  logic [AW-1:0]   fwd_addr2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic [XLEN-1:0] fwd_data
);

  import rf_pkg::*;

  logic [NUM_WB_SRC-1:0] req;
  logic [NUM_WB_SRC-1:0] grant;
  logic                  xfer;
  logic [AW-1:0]         sel_addr;
  logic [XLEN-1:0]       sel_data;

  logic                  stg_valid_q, stg_valid_d;
  logic [AW-1:0]         stg_addr_q,  stg_addr_d;
  logic [XLEN-1:0]       stg_data_q,  stg_data_d;

  assign req = {wb1_valid, wb0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .hold_i  (rf_hold),
    .grant_o (grant)
  );

  assign wb0_ready = grant[0];
  assign wb1_ready = grant[1];
  assign xfer      = |grant;

  // Grant is one-hot, so a simple 2:1 mux on grant[1] selects the winner.
  assign sel_addr = grant[1] ? wb1_addr : wb0_addr;
  assign sel_data = grant[1] ? wb1_data : wb0_data;

  // While held the stage is frozen; otherwise it takes the accepted request
  // or empties. x0 writes are accepted but never become valid. Address/data
  // are only refreshed for real writes, so the bypass data path only ever
  // shows something that was actually destined for the register file.
  always_comb begin
    stg_valid_d = stg_valid_q;
    stg_addr_d  = stg_addr_q;
    stg_data_d  = stg_data_q;
    if (!rf_hold) begin
      stg_valid_d = xfer && (sel_addr != '0);
      if (stg_valid_d) begin
        stg_addr_d = sel_addr;
        stg_data_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_addr_q  <= stg_addr_d;
      stg_data_q  <= stg_data_d;
    end
  end

  assign wr_en   = stg_valid_q && !rf_hold;
  assign wr_addr = stg_addr_q;
  assign wr_data = stg_data_q;

  // Bypass stays live during hold so readers still see the pending value.
  assign fwd_hit1 = stg_valid_q && (stg_addr_q == fwd_addr1);
  assign fwd_hit2 = stg_valid_q && (stg_addr_q == fwd_addr2);
  assign fwd_data = stg_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  import rf_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [AW-1:0]   wb0_addr, wb1_addr;
  logic [XLEN-1:0] wb0_data, wb1_data;
  logic            rf_hold;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [AW-1:0]   fwd_addr1, fwd_addr2;
  logic            fwd_hit1, fwd_hit2;
  logic [XLEN-1:0] fwd_data;

  rf_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rf_hold(rf_hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    int              cyc;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  exp_t            exp_q[$];     // accepted, not yet written
  wb_req_t         src0_q[$];    // pending ALU requests
  wb_req_t         src1_q[$];    // pending LSU requests
  int              wr_log[$];    // addresses written, in order
  logic [XLEN-1:0] rf_mem [32];  // register file driven by the DUT write port
  logic [XLEN-1:0] exp_rf [32];
  int              last_src = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: arbitration rules and acceptance, evaluated mid-cycle.
  always @(negedge clk) begin
    int              win;
    logic [1:0]      eg;
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    if (!rst_n) begin
      last_src = 1;
    end else begin
      win = -1;
      eg  = 2'b00;
      if (!rf_hold) begin
        if (wb0_valid && wb1_valid) win = (last_src == 0) ? 1 : 0;
        else if (wb0_valid)         win = 0;
        else if (wb1_valid)         win = 1;
      end
      if (win == 0) eg = 2'b01;
      if (win == 1) eg = 2'b10;
      check("readies", {62'd0, wb1_ready, wb0_ready}, {62'd0, eg});
      if (win >= 0) begin
        last_src = win;
        a = (win == 1) ? wb1_addr : wb0_addr;
        d = (win == 1) ? wb1_data : wb0_data;
        if (a != '0) exp_q.push_back('{addr: a, data: d, cyc: cyc});
        $display("cycle %0d: accept src%0d x%0d=%h", cyc, win, a, d);
      end
    end
  end

  // Monitor: compares the write port and bypass against the pending queue.
  always @(negedge clk) begin
    logic            staged;
    logic [AW-1:0]   sa;
    logic [XLEN-1:0] sd;
    if (!rst_n) begin
      exp_q.delete();
      check("reset_wr_en", {63'd0, wr_en}, 64'd0);
      check("reset_fwd_hits", {62'd0, fwd_hit1, fwd_hit2}, 64'd0);
    end else begin
      staged = (exp_q.size() > 0) && (exp_q[0].cyc < cyc);
      sa = staged ? exp_q[0].addr : '0;
      sd = staged ? exp_q[0].data : '0;
      check("fwd_hit1", {63'd0, fwd_hit1}, {63'd0, staged && (sa == fwd_addr1)});
      check("fwd_hit2", {63'd0, fwd_hit2}, {63'd0, staged && (sa == fwd_addr2)});
      if (staged) check("fwd_data", {32'd0, fwd_data}, {32'd0, sd});
      check("wr_en", {63'd0, wr_en}, {63'd0, staged && !rf_hold});
      if (staged && !rf_hold) begin
        check("wr_addr", {59'd0, wr_addr}, {59'd0, sa});
        check("wr_data", {32'd0, wr_data}, {32'd0, sd});
        void'(exp_q.pop_front());
      end
      if (wr_en) begin
        rf_mem[wr_addr] = wr_data;
        wr_log.push_back(int'(wr_addr));
        $display("cycle %0d: write x%0d=%h", cyc, wr_addr, wr_data);
      end
    end
  end

  task automatic drive();
    wb0_valid = (src0_q.size() > 0);
    wb0_addr  = wb0_valid ? src0_q[0].addr : '0;
    wb0_data  = wb0_valid ? src0_q[0].data : '0;
    wb1_valid = (src1_q.size() > 0);
    wb1_addr  = wb1_valid ? src1_q[0].addr : '0;
    wb1_data  = wb1_valid ? src1_q[0].data : '0;
  endtask

  // One clock: note handshakes mid-cycle, advance sources after the edge.
  task automatic step();
    logic h0, h1;
    @(negedge clk);
    h0 = wb0_valid && wb0_ready;
    h1 = wb1_valid && wb1_ready;
    @(posedge clk);
    #1;
    if (h0) void'(src0_q.pop_front());
    if (h1) void'(src1_q.pop_front());
    drive();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((src0_q.size() > 0 || src1_q.size() > 0) && n < limit) begin
      step();
      n++;
    end
    check("drain_in_budget", {63'd0, (n < limit)}, 64'd1);
    repeat (3) step();
  endtask

  task automatic push(input int src, input int a, input logic [XLEN-1:0] d);
    wb_req_t r;
    r.addr = a[AW-1:0];
    r.data = d;
    if (src == 0) src0_q.push_back(r);
    else          src1_q.push_back(r);
  endtask

  initial begin
    int exp_ord[8];
    rst_n = 1'b0; rf_hold = 1'b0; fwd_addr1 = '0; fwd_addr2 = '0;
    drive();
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    check("post_reset_fwd_data", {32'd0, fwd_data}, 64'd0);
    check("post_reset_wr_en", {63'd0, wr_en}, 64'd0);

    // Contention: ALU x1..x4 vs LSU x5..x8 must alternate starting with ALU.
    exp_ord = '{1, 5, 2, 6, 3, 7, 4, 8};
    wr_log.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, i + 1, $urandom);
      push(1, i + 5, $urandom);
    end
    drive();
    drain(40);
    check("contention_count", 64'(wr_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < wr_log.size(); i++)
      check("contention_order", 64'(wr_log[i]), 64'(exp_ord[i]));

    // x0 drop: accepted, no write, then LSU wins the next contention.
    wr_log.delete();
    push(0, 0, 32'hDEADBEEF);
    drive();
    #3 check("x0_ready", {63'd0, wb0_ready}, 64'd1);
    step();
    #3 check("x0_no_write", {63'd0, wr_en}, 64'd0);
    push(0, 9, $urandom);
    push(1, 10, $urandom);
    drive();
    drain(20);
    check("x0_count", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() > 0) check("x0_then_lsu", 64'(wr_log[0]), 64'd10);

    // Hold: x7 staged, frozen for 3 cycles, written on release.
    fwd_addr1 = 5'd7;
    push(0, 7, 32'h1234);
    drive();
    step();
    rf_hold = 1'b1;
    push(1, 11, $urandom);
    drive();
    for (int i = 0; i < 3; i++) begin
      #3;
      check("hold_wr_en", {63'd0, wr_en}, 64'd0);
      check("hold_readies", {62'd0, wb1_ready, wb0_ready}, 64'd0);
      check("hold_fwd_hit1", {63'd0, fwd_hit1}, 64'd1);
      check("hold_fwd_data", {32'd0, fwd_data}, 64'h1234);
      step();
    end
    rf_hold = 1'b0;
    #3;
    check("release_wr_en", {63'd0, wr_en}, 64'd1);
    check("release_wr_addr", {59'd0, wr_addr}, 64'd7);
    check("release_wr_data", {32'd0, wr_data}, 64'h1234);
    drain(20);

    // Forwarding.
    fwd_addr1 = 5'd3;
    fwd_addr2 = 5'd4;
    push(0, 3, 32'hA5A5A5A5);
    drive();
    step();
    #3;
    check("fwd_x3_hit1", {63'd0, fwd_hit1}, 64'd1);
    check("fwd_x3_hit2", {63'd0, fwd_hit2}, 64'd0);
    check("fwd_x3_data", {32'd0, fwd_data}, 64'hA5A5A5A5);
    drain(20);

    // Mid-stream reset with a live stage.
    for (int i = 0; i < 6; i++) begin
      push(0, 1 + ($urandom % 31), $urandom);
      push(1, 1 + ($urandom % 31), $urandom);
    end
    drive();
    step(); step();
    rst_n = 1'b0;
    #1 check("midreset_wr_en", {63'd0, wr_en}, 64'd0);
    src0_q.delete(); src1_q.delete();
    drive();
    #99;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr_log.delete();
    push(0, 12, $urandom);
    push(1, 13, $urandom);
    drive();
    drain(20);
    check("post_reset_count", 64'(wr_log.size()), 64'd2);
    if (wr_log.size() > 0) check("post_reset_alu_first", 64'(wr_log[0]), 64'd12);

    // Randomized traffic with holds and bypass probing.
    for (int c = 0; c < 300; c++) begin
      if (src0_q.size() < 3 && ($urandom % 2) == 0) push(0, $urandom % 32, $urandom);
      if (src1_q.size() < 3 && ($urandom % 2) == 0) push(1, $urandom % 32, $urandom);
      rf_hold   = (($urandom % 5) == 0);
      fwd_addr1 = AW'($urandom);
      fwd_addr2 = AW'($urandom);
      drive();
      step();
    end
    rf_hold = 1'b0;
    drain(40);

    // Full sweep through the register file.
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = '0;
      exp_rf[i] = '0;
    end
    push(0, 0, $urandom);
    for (int a = 1; a < 32; a++) begin
      exp_rf[a] = $urandom;
      push(a % 2, a, exp_rf[a]);
    end
    drive();
    drain(100);
    for (int a = 0; a < 32; a++)
      check($sformatf("sweep_x%0d", a), {32'd0, rf_mem[a]}, {32'd0, exp_rf[a]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter AW, default 5, register address width (32 architectural registers).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports wb0_valid/wb0_ready  in/out  1/1  ALU writeback handshake (source 0).
REQ-006 SHALL have ports wb0_addr/wb0_data  in  AW/XLEN  ALU destination register and result.
REQ-007 SHALL have ports wb1_valid/wb1_ready  in/out  1/1  LSU writeback handshake (source 1).
REQ-008 SHALL have ports wb1_addr/wb1_data  in  AW/XLEN  LSU destination register and load data.
REQ-009 SHALL have port rf_hold  in  1  freezes register-file writes (debug halt).
REQ-010 SHALL have ports wr_en/wr_addr/wr_data  out  1/AW/XLEN  drive the register file's single write port.
REQ-011 SHALL have ports fwd_addr1/fwd_addr2  in  AW  read-port addresses currently presented to the register file.
REQ-012 SHALL have ports fwd_hit1/fwd_hit2  out  1  staged write targets the matching read address.
REQ-013 SHALL have port fwd_data  out  XLEN  staged write data for bypass.

Function
REQ-014 SHALL transfer a request only on valid&&ready in the same cycle; valid SHALL NOT depend on ready.
REQ-015 SHALL assert at most one of wb0_ready/wb1_ready per cycle; both 0 while rf_hold=1.
REQ-016 SHALL derive readies combinationally from wb0_valid, wb1_valid, rf_hold, and the last_grant register.
REQ-017 With one source valid and rf_hold=0, SHALL grant that source.
REQ-018 With both sources valid, SHALL grant the source not recorded in last_grant (round-robin); last_grant SHALL update on every transfer.
REQ-019 An accepted request SHALL load the stage register (stg_valid, stg_addr, stg_data); wr_en/wr_addr/wr_data SHALL present it in the next cycle (latency 1).
REQ-020 A request with addr=0 SHALL be accepted and update last_grant, but SHALL NOT set stg_valid (x0 writes dropped).
REQ-021 wr_en SHALL equal stg_valid && !rf_hold; wr_addr/wr_data SHALL equal stg_addr/stg_data.
REQ-022 While rf_hold=1, the stage SHALL hold its contents unchanged; on release, the held entry SHALL be written in the first cycle with rf_hold=0.
REQ-023 If rf_hold=0, the stage SHALL be overwritten each cycle by the accepted request, or cleared (stg_valid=0) if there is none.
REQ-024 fwd_hitN SHALL be stg_valid && (stg_addr == fwd_addrN), combinational; fwd_data SHALL equal stg_data.
REQ-025 fwd_hitN SHALL remain asserted during rf_hold so held data stays visible to readers.

Reset
REQ-026 On rst_n=0, asynchronously: stg_valid=0, stg_addr=0, stg_data=0, last_grant=1 (source 0 wins first contention).
REQ-027 During and after reset, until the first transfer: wr_en=0, fwd_hit1=fwd_hit2=0, fwd_data=0.
REQ-028 Reset mid-operation SHALL discard the staged entry without writing it.

Structure
REQ-029 Shared package rf_pkg SHALL hold XLEN, AW, NUM_WB_SRC=2, and typedef wb_req_t {addr, data}.
REQ-030 Arbitration SHALL be one sub-module, rr_arb2 (2-way round-robin with a last_grant flop); staging and forwarding SHALL live in the top level.

Verification
REQ-031 Reset: assert rst_n=0 for 100 ns mid-stream -> wr_en=0 immediately; first post-reset contention grants source 0.
REQ-032 Contention: both valid for 4 cycles (ALU x1..x4, LSU x5..x8) -> writes alternate x1,x5,x2,x6,... each one cycle after its grant.
REQ-033 x0 drop: wb0 addr=0 data=32'hDEADBEEF -> wb0_ready=1, no wr_en the next cycle, then LSU wins the following contention.
REQ-034 Hold: stage x7=32'h1234 then rf_hold=1 for 3 cycles -> wr_en=0, readies 0, fwd_hit1=1 for fwd_addr1=7; x7 written in the first cycle after release.
REQ-035 Forwarding: stage x3=32'hA5A5A5A5 with fwd_addr1=3, fwd_addr2=4 -> fwd_hit1=1, fwd_hit2=0, fwd_data=32'hA5A5A5A5.
REQ-036 Full sweep: write x1..x31 with random data, then read back through the register file -> all match; x0 reads 0.
